ps2_host_tx: RTL and testbench

//   Host-to-device PS/2 transmitter: sends one command byte, e.g. 0xED set-LEDs or 0xFF reset, to the keyboard.

---
 rtl/ps2_host_tx.sv | 239 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain OEs.
// Optional PS2_TX_RETRY_EN: one automatic retry after a NACK or timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned REQ_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT
  } state_t;

  localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] REQ_LAST = 32'(REQ_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CODE_TMO  = 2'b01;
  localparam logic [1:0] CODE_NACK = 2'b10;

  state_t      state;
  state_t      state_n;
  logic [31:0] cnt;
  logic [3:0]  edge_cnt;
  logic [9:0]  frame;

  logic clk_s1;
  logic clk_s2;
  logic clk_prev;
  logic data_s1;
  logic data_s2;

  logic       fall;
  logic       tmo;
  logic       accept;
  logic       fail;
  logic [1:0] fail_code;
  logic       fin;
  logic       retry_ok;
  logic       cnt_clr;

  logic       clk_oe_d;
  logic       data_oe_d;
  logic       done_d;
  logic       err_d;
  logic       busy_d;
  logic       ready_d;
  logic [1:0] err_code_d;

  assign fall   = clk_prev & ~clk_s2;
  assign tmo    = (cnt == TMO_LAST);
  assign accept = tx_valid & tx_ready;

`ifdef PS2_TX_RETRY_EN
  logic retried;

  assign retry_ok = ~retried;

  always_ff @(posedge clk) begin
    if (rst) begin
      retried <= 1'b0;
    end else if (accept) begin
      retried <= 1'b0;
    end else if (fail) begin
      retried <= 1'b1;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  // Idle bus is high, so sync chains reset high to avoid a phantom edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    fail      = 1'b0;
    fail_code = 2'b00;
    fin       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt == INH_LAST) begin
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (cnt == REQ_LAST) begin
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (tmo) begin
          fail      = 1'b1;
          fail_code = CODE_TMO;
        end else if (fall && edge_cnt == 4'd9) begin
          state_n = S_ACK;
        end
      end
      S_ACK: begin
        if (tmo) begin
          fail      = 1'b1;
          fail_code = CODE_TMO;
        end else if (fall) begin
          if (data_s2) begin
            fail      = 1'b1;
            fail_code = CODE_NACK;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (clk_s2 && data_s2) begin
          state_n = S_IDLE;
          fin     = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (fail) begin
      state_n = retry_ok ? S_INHIBIT : S_IDLE;
    end
  end

  always_comb begin
    clk_oe_d   = 1'b0;
    data_oe_d  = 1'b0;
    busy_d     = (state_n != S_IDLE);
    ready_d    = (state_n == S_IDLE);
    done_d     = fin;
    err_d      = fail & ~retry_ok;
    err_code_d = err_d ? fail_code : err_code;
    unique case (state_n)
      S_INHIBIT: begin
        clk_oe_d = 1'b1;
      end
      S_REQ: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b1;
      end
      S_SEND: begin
        if (state == S_REQ) begin
          data_oe_d = 1'b1;
        end else if (fall) begin
          data_oe_d = ~frame[edge_cnt];
        end else begin
          data_oe_d = ps2_data_oe;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

  // Timeout spans SEND and ACK, so that one transition keeps counting.
  assign cnt_clr = (state == S_IDLE) ||
                   ((state_n != state) &&
                    !(state == S_SEND && state_n == S_ACK));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      edge_cnt    <= '0;
      frame       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      cnt         <= cnt_clr ? '0 : cnt + 32'd1;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      busy        <= busy_d;
      tx_ready    <= ready_d;
      done        <= done_d;
      err         <= err_d;
      err_code    <= err_code_d;
      if (accept) begin
        frame <= {1'b1, ~^tx_data, tx_data};
      end
      if (state_n == S_INHIBIT) begin
        edge_cnt <= '0;
      end else if (state == S_SEND && fall) begin
        edge_cnt <= edge_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a simple PS/2 device model.
// Also covers the PS2_TX_RETRY_EN build when that macro is defined.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int RQ  = 8;
  localparam int TMO = 3000;
  localparam int H   = 20;
  localparam int LIM = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  wire ps2_clk_pin  = ps2_clk_oe  ? 1'b0 : dev_clk;
  wire ps2_data_pin = ps2_data_oe ? 1'b0 : dev_data;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int d0;
  int e0;
  int k;
  logic [9:0] bits;
  logic [8:0] ed_exp;
  logic [7:0] sweep_b [4];
  logic [9:0] sweep_f [4];

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (RQ),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .ps2_clk_in (ps2_clk_pin),
    .ps2_data_in(ps2_data_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done | err) check("done_err_excl", done & err, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int w;
    w = 0;
    while (!tx_ready && w < LIM) begin
      tick();
      w++;
    end
    check("tx_ready", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic dev_xfer(input bit ack, input int stop_at,
                          output logic [9:0] fr);
    int w;
    w  = 0;
    fr = '0;
    while (!ps2_clk_oe && w < LIM) begin
      tick();
      w++;
    end
    while (ps2_clk_oe && w < LIM) begin
      tick();
      w++;
    end
    check("rts_release", w < LIM, 1);
    check("start_bit", ps2_data_oe, 1);
    for (int n = 1; n <= 11; n++) begin
      repeat (H) tick();
      if (n == 11) dev_data = ack ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      repeat (H) tick();
      if (n <= 10) fr[n-1] = ps2_data_pin;
      if (n == stop_at) return;
      dev_clk = 1'b1;
    end
    repeat (2) tick();
    dev_data = 1'b1;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 4 * LIM) begin
      tick();
      w++;
    end
    check("idle_reached", busy, 0);
    repeat (2) tick();
  endtask

  task automatic xfer_ok(input logic [7:0] b, input logic [9:0] exp_fr);
    int dd;
    int ee;
    dd = done_cnt;
    ee = err_cnt;
    send(b);
    dev_xfer(1'b1, 0, bits);
    wait_idle();
    check("frame", bits, exp_fr);
    check("done_once", done_cnt - dd, 1);
    check("no_err", err_cnt - ee, 0);
    check("oe_idle", {ps2_clk_oe, ps2_data_oe}, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_ready", tx_ready, 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", tx_ready, 1);

    xfer_ok(8'hED, 10'h3ED);
    ed_exp = 9'h1ED;
    for (int i = 0; i < 9; i++) check("ed_bit", bits[i], ed_exp[i]);

    sweep_b[0] = 8'h00; sweep_f[0] = 10'h300;
    sweep_b[1] = 8'h01; sweep_f[1] = 10'h201;
    sweep_b[2] = 8'hFF; sweep_f[2] = 10'h3FF;
    sweep_b[3] = 8'h80; sweep_f[3] = 10'h280;
    for (int i = 0; i < 4; i++) xfer_ok(sweep_b[i], sweep_f[i]);

    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hFF);
    k = 0;
    while (ps2_clk_oe && k < LIM) begin tick(); k++; end
    check("inhibit_req_len", k, INH + RQ);
`ifdef PS2_TX_RETRY_EN
    k = 0;
    while (!ps2_clk_oe && k < TMO + 10) begin tick(); k++; end
    check("retry_tmo_len", k, TMO);
    check("retry_busy", busy, 1);
    check("retry_no_err", err_cnt - e0, 0);
    k = 0;
    while (ps2_clk_oe && k < LIM) begin tick(); k++; end
    check("retry_inhibit_len", k, INH + RQ);
`endif
    k = 0;
    while (!err && k < TMO + 10) begin tick(); k++; end
    check("tmo_len", k, TMO);
    check("tmo_code", err_code, 2'b01);
    check("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("tmo_busy", busy, 0);
    tick();
    check("err_pulse", err, 0);
    check("err_code_hold", err_code, 2'b01);
    check("tmo_err_once", err_cnt - e0, 1);
    check("tmo_no_done", done_cnt - d0, 0);

    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00);
    dev_xfer(1'b0, 0, bits);
`ifdef PS2_TX_RETRY_EN
    dev_xfer(1'b1, 0, bits);
    wait_idle();
    check("retry_frame", bits, 10'h300);
    check("retry_done", done_cnt - d0, 1);
    check("retry_no_err2", err_cnt - e0, 0);
`else
    wait_idle();
    check("nack_frame", bits, 10'h300);
    check("nack_code", err_code, 2'b10);
    check("nack_err", err_cnt - e0, 1);
    check("nack_no_done", done_cnt - d0, 0);
`endif

    send(8'hA5);
    d0 = done_cnt;
    e0 = err_cnt;
    dev_xfer(1'b1, 4, bits);
    check("pre_rst_bits", bits[3:0], 4'h5);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pulses", {done, err}, 0);
    rst = 1'b0;
    dev_clk = 1'b1;
    tick();
    check("post_rst_ready", tx_ready, 1);
    repeat (5) tick();
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_err", err_cnt - e0, 0);
    xfer_ok(8'h55, 10'h355);

    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hF4);
    fork
      dev_xfer(1'b1, 0, bits);
      begin
        repeat (300) tick();
        check("busy_mid", busy, 1);
        check("ready_mid", tx_ready, 0);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
      end
    join
    wait_idle();
    repeat (200) tick();
    check("ovl_frame", bits, 10'h2F4);
    check("ovl_done_once", done_cnt - d0, 1);
    check("ovl_no_err", err_cnt - e0, 0);
    check("ovl_no_requeue", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
